// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift unit: op codes, amount sources and FSM states.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] SA_RT    = 2'b00;
  localparam logic [1:0] SA_SHAMT = 2'b01;
  localparam logic [1:0] SA_MEM   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/result bundle between the control FSM (master) and the shift unit (slave).
interface shift_unit_seq_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = $clog2(DATA_W)
);
  logic              start;
  logic [1:0]        op;
  logic [1:0]        amt_sel;
  logic [AMT_W-1:0]  amt_rt;
  logic [AMT_W-1:0]  amt_shamt;
  logic [AMT_W-1:0]  amt_mem;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;

  modport master (
    output start, op, amt_sel, amt_rt, amt_shamt, amt_mem, data_in,
    input  data_out, busy, done
  );

  modport slave (
    input  start, op, amt_sel, amt_rt, amt_shamt, amt_mem, data_in,
    output data_out, busy, done
  );
endinterface

// File: rtl/shift_amt_sel.sv
// Three-way shift-amount source mux; amt_sel[1] selects the memory operand regardless of bit 0.
module shift_amt_sel
  import shift_pkg::*;
#(
  parameter int unsigned AMT_W = 5
) (
  input  logic [1:0]       amt_sel,
  input  logic [AMT_W-1:0] amt_rt,
  input  logic [AMT_W-1:0] amt_shamt,
  input  logic [AMT_W-1:0] amt_mem,
  output logic [AMT_W-1:0] amt
);

  always_comb begin
    amt = amt_rt;
    if (amt_sel[1]) begin
      amt = amt_mem;
    end else if (amt_sel == SA_SHAMT) begin
      amt = amt_shamt;
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shift unit, one bit per clock under a start/done handshake.
// Define SHIFT_UNIT_BARREL_EN to replace the iterative shift with a single-cycle barrel shift.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = $clog2(DATA_W)
) (
  input logic           clk,
  input logic           reset,
  shift_unit_seq_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AMT_W-1:0]  count_q, count_d;
  logic [1:0]        op_q, op_d;
  logic [AMT_W-1:0]  amt;

  shift_amt_sel #(
    .AMT_W(AMT_W)
  ) u_amt_sel (
    .amt_sel  (bus.amt_sel),
    .amt_rt   (bus.amt_rt),
    .amt_shamt(bus.amt_shamt),
    .amt_mem  (bus.amt_mem),
    .amt      (amt)
  );

`ifdef SHIFT_UNIT_BARREL_EN
  function automatic logic [DATA_W-1:0] barrel(input logic [DATA_W-1:0] d,
                                                input logic [AMT_W-1:0]  n,
                                                input logic [1:0]        o);
    logic [2*DATA_W-1:0] rot;
    rot = {d, d} >> n;
    case (o)
      OP_SLL:  barrel = d << n;
      OP_SRL:  barrel = d >> n;
      OP_SRA:  barrel = $signed(d) >>> n;
      default: barrel = rot[DATA_W-1:0];
    endcase
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          count_d = amt;
`ifdef SHIFT_UNIT_BARREL_EN
          data_d  = barrel(bus.data_in, amt, bus.op);
          state_d = ST_DONE;
`else
          data_d  = bus.data_in;
          state_d = (amt == '0) ? ST_DONE : ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: begin
        case (op_q)
          OP_SLL:  data_d = {data_q[DATA_W-2:0], 1'b0};
          OP_SRL:  data_d = {1'b0, data_q[DATA_W-1:1]};
          OP_SRA:  data_d = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
          default: data_d = {data_q[0], data_q[DATA_W-1:1]};
        endcase
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  // Moore outputs: decoded purely from registered state.
  assign bus.data_out = data_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised sequential shift unit for the multicycle datapath; successor of the shift-amount source mux.
- Selects the shift amount from one of three sources (rt, shamt, memory operand).
- Loads the operand and shifts it one bit per clock under a start/done handshake.
- Supports logical left, logical right, arithmetic right and rotate right; result is held on data_out for the control FSM and writeback mux.

Parameters:
- DATA_W, 32, operand/result width (≥2).
- AMT_W, $clog2(DATA_W), shift-amount width (5 for DATA_W=32).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- amt_sel  input  2  00 amt_rt, 01 amt_shamt, 1x amt_mem (bit 1 dominates).
- amt_rt  input  AMT_W  amount from rt.
- amt_shamt  input  AMT_W  amount from instruction shamt field.
- amt_mem  input  AMT_W  amount from Mem[offset+rs].
- data_in  input  DATA_W  operand.
- data_out  output  DATA_W  shift register contents / result.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, data_out=0, count=0, op_q=00, busy=0, done=0.
- Reset wins over every other input, including mid-shift; a partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - data_out<=data_in; op_q<=op; count<=selected amount N.
  - Next state: N==0 → DONE, else SHIFT.
- IDLE, start=0: hold data_out (the last result stays readable).
- SHIFT, each edge:
  - SLL: data_out<={data_out[DATA_W-2:0],1'b0}.
  - SRL: data_out<={1'b0,data_out[DATA_W-1:1]}.
  - SRA: data_out<={data_out[DATA_W-1],data_out[DATA_W-1:1]}.
  - ROR: data_out<={data_out[0],data_out[DATA_W-1:1]}.
  - count<=count-1; when count==1, next state is DONE.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- Latency: done is high in the cycle after edge E0+N, i.e. N+1 edges after the start edge. N=0 → done in the cycle right after E0, with data_out equal to data_in.
- start while busy is ignored; it is not queued.
- start in the same cycle as the DONE state is also ignored; the earliest new start is in the following IDLE cycle.
- Amount inputs, op and data_in are don't-care except at the start edge; they are registered at start.
- Max amount is DATA_W-1; no overflow case exists by construction.
- busy and done are decoded from the state register (Moore); no combinational input→output paths.

Optional Feature:
- Macro: SHIFT_UNIT_BARREL_EN.
- Defined:
  - SHIFT state is bypassed.
  - At start, data_out<=full barrel shift of data_in by N under op; next state is DONE.
  - done is always high in the cycle after E0, for any N.
- Undefined: iterative one-bit-per-cycle behaviour above.
- Final results are identical in both builds; only latency differs.

Decomposition:
- Package shift_pkg:
  - op localparams OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11.
  - amount-source localparams SA_RT=2'b00, SA_SHAMT=2'b01, SA_MEM=2'b10.
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_amt_sel (parametrised AMT_W): the combinational 3-way amount-source mux, instantiated once.
- The FSM, counter and shift register stay in shift_unit_seq.

Test Plan:
- Reset mid-shift: DATA_W=32, data_in=32'h8000_0001, op=SRA, amt_sel=01, shamt=4, start; reset asserted 2 cycles later → data_out=0, busy=0, done=0 next edge; a fresh start afterwards works normally.
- SLL via rt: data_in=32'h0000_00FF, amt_rt=8, amt_sel=00 → done 9 edges after start, data_out=32'h0000_FF00, busy high for 9 cycles.
- SRA vs SRL via mem: data_in=32'hF000_0000, amt_mem=4, amt_sel=10 (then 11) → SRA result 32'hFF00_0000; repeat with SRL → 32'h0F00_0000; amt_sel=11 must also select amt_mem.
- ROR wrap: data_in=32'h0000_0001, ROR by 1 → 32'h8000_0000; ROR by 31 → 32'h0000_0002.
- Zero amount, ignored start: N=0 → done the cycle after start with data_out=data_in; a start pulsed during SHIFT of an 8-bit shift is ignored, exactly one done seen.
- SHIFT_UNIT_BARREL_EN build: the directed cases above give identical data_out with done always 1 edge after start.
